// File: rtl/td4_core.sv
`default_nettype none
// ============================================================================
//  Module   : td4_core
//  Purpose  : 4-bit accumulator CPU core (TD4-style ISA). Executes one 8-bit
//             instruction per cpu_en strobe, fetched combinationally from an
//             external 16x8 program ROM. cpu_en is a clock enable on clk,
//             never a derived clock.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC   PC value loaded on reset
//    OUT_RESET  out_port value loaded on reset
//  Ports
//    clk       in   1  system clock, all state on rising edge
//    reset_n   in   1  synchronous active-low reset (overrides cpu_en)
//    cpu_en    in   1  one-cycle execute strobe
//    rom_addr  out  4  program address (= PC)
//    rom_data  in   8  instruction at rom_addr: [7:4] opcode, [3:0] Im
//    in_port   in   4  input switches, sampled on execute
//    out_port  out  4  registered output port
//    reg_a     out  4  register A (debug)
//    reg_b     out  4  register B (debug)
//    carry     out  1  carry flag
//    halted    out  1  stop-loop indicator
//  Configuration
//    TD4_HALT_DETECT_EN  when defined, halted sets on an executed JMP or
//                        taken JNC whose target equals its own address and
//                        stays set until reset. When undefined, halted = 0.
// ============================================================================
module td4_core #(
    parameter logic [3:0] RESET_PC  = 4'd0,
    parameter logic [3:0] OUT_RESET = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_en,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry,
    output logic       halted
);

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A  = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B  = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_JNC   = 4'b1110;
    localparam logic [3:0] OP_JMP   = 4'b1111;

    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       carry_q, carry_d;

    logic [3:0] opcode;
    logic [3:0] imm;
    logic [4:0] sum_a;
    logic [4:0] sum_b;

    assign opcode = rom_data[7:4];
    assign imm    = rom_data[3:0];

    // 5-bit sums of zero-extended operands; bit 4 becomes the new carry
    assign sum_a = {1'b0, a_q} + {1'b0, imm};
    assign sum_b = {1'b0, b_q} + {1'b0, imm};

`ifdef TD4_HALT_DETECT_EN
    logic halted_q, halted_d;
`endif

    always_comb begin
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
`ifdef TD4_HALT_DETECT_EN
        halted_d = halted_q;
`endif
        if (cpu_en) begin
            // Defaults for an executed instruction: advance PC (wraps 15->0
            // naturally in 4 bits) and clear carry unless an ADD sets it.
            pc_d    = pc_q + 4'd1;
            carry_d = 1'b0;
            case (opcode)
                OP_ADD_A: begin
                    a_d     = sum_a[3:0];
                    carry_d = sum_a[4];
                end
                OP_ADD_B: begin
                    b_d     = sum_b[3:0];
                    carry_d = sum_b[4];
                end
                OP_MOV_AI: a_d   = imm;
                OP_MOV_BI: b_d   = imm;
                OP_MOV_AB: a_d   = b_q;
                OP_MOV_BA: b_d   = a_q;
                OP_IN_A:   a_d   = in_port;
                OP_IN_B:   b_d   = in_port;
                OP_OUT_B:  out_d = b_q;
                OP_OUT_I:  out_d = imm;
                OP_JMP: begin
                    pc_d = imm;
`ifdef TD4_HALT_DETECT_EN
                    if (imm == pc_q) halted_d = 1'b1;
`endif
                end
                OP_JNC: begin
                    // Tests the carry held before this instruction executes
                    if (!carry_q) begin
                        pc_d = imm;
`ifdef TD4_HALT_DETECT_EN
                        if (imm == pc_q) halted_d = 1'b1;
`endif
                    end
                end
                default: ;  // NOP: only PC advance and carry clear
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            out_q   <= OUT_RESET;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

`ifdef TD4_HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) halted_q <= 1'b0;
        else          halted_q <= halted_d;
    end
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign rom_addr = pc_q;
    assign out_port = out_q;
    assign reg_a    = a_q;
    assign reg_b    = b_q;
    assign carry    = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_td4_core
//  Purpose  : Self-checking bench for td4_core: a table of directed vectors
//             over a fixed program plus hand-written multi-cycle sequences
//             (reset, enable gating, PC wrap with I/O, mid-op reset, halt).
//  Revision : 1.0  initial release
// ============================================================================
module tb_td4_core;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_en = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] in_port = 4'd0;
    logic [3:0] out_port;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic       carry;
    logic       halted;

    logic [7:0] rom [16];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef TD4_HALT_DETECT_EN
    localparam logic HALT_EXP = 1'b1;
`else
    localparam logic HALT_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    td4_core #(
        .RESET_PC  (4'd0),
        .OUT_RESET (4'd0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_en   (cpu_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .in_port  (in_port),
        .out_port (out_port),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .carry    (carry),
        .halted   (halted)
    );

    typedef struct {
        logic       rn;
        logic       en;
        logic [3:0] inp;
        logic [3:0] pc;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] o;
    } vec_t;

    vec_t vecs [17];

    // Drive inputs at the falling edge, then sample 1 time unit after the
    // following rising edge.
    task automatic step(input logic rn, input logic en, input logic [3:0] inp);
        @(negedge clk);
        reset_n = rn;
        cpu_en  = en;
        in_port = inp;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] pc, input logic [3:0] a,
                             input logic [3:0] b, input logic c, input logic [3:0] o);
        chk({tag, ".pc"},    rom_addr,        pc);
        chk({tag, ".a"},     reg_a,           a);
        chk({tag, ".b"},     reg_b,           b);
        chk({tag, ".carry"}, {3'b0, carry},   {3'b0, c});
        chk({tag, ".out"},   out_port,        o);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;  // NOP
    endtask

    initial begin
        clear_rom();
        // Program for the vector table
        rom[0]  = 8'h3E;  // MOV A,E
        rom[1]  = 8'h03;  // ADD A,3   -> A=1, C=1
        rom[2]  = 8'hE0;  // JNC 0     -> not taken, C=0
        rom[3]  = 8'hBA;  // OUT Im A
        rom[4]  = 8'h7C;  // MOV B,C
        rom[5]  = 8'h54;  // ADD B,4   -> B=0, C=1
        rom[6]  = 8'h00;  // ADD A,0   -> A=1, C=0
        rom[7]  = 8'hE9;  // JNC 9     -> taken
        rom[8]  = 8'h3F;  // skipped
        rom[9]  = 8'h20;  // IN A
        rom[10] = 8'h40;  // MOV B,A
        rom[11] = 8'h53;  // ADD B,3
        rom[12] = 8'h10;  // MOV A,B
        rom[13] = 8'h90;  // OUT B
        rom[14] = 8'h80;  // NOP
        rom[15] = 8'hF0;  // JMP 0

        //            rn    en    inp    pc     a      b      c     out
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'd0,  4'h0, 4'h0, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'hF, 4'd1,  4'hE, 4'h0, 1'b0, 4'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'h0, 4'd2,  4'h1, 4'h0, 1'b1, 4'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'h7, 4'd2,  4'h1, 4'h0, 1'b1, 4'h0};
        vecs[4]  = '{1'b1, 1'b1, 4'h0, 4'd3,  4'h1, 4'h0, 1'b0, 4'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 4'd4,  4'h1, 4'h0, 1'b0, 4'hA};
        vecs[6]  = '{1'b1, 1'b1, 4'h0, 4'd5,  4'h1, 4'hC, 1'b0, 4'hA};
        vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'd6,  4'h1, 4'h0, 1'b1, 4'hA};
        vecs[8]  = '{1'b1, 1'b1, 4'h0, 4'd7,  4'h1, 4'h0, 1'b0, 4'hA};
        vecs[9]  = '{1'b1, 1'b1, 4'h0, 4'd9,  4'h1, 4'h0, 1'b0, 4'hA};
        vecs[10] = '{1'b1, 1'b1, 4'h6, 4'd10, 4'h6, 4'h0, 1'b0, 4'hA};
        vecs[11] = '{1'b1, 1'b1, 4'h0, 4'd11, 4'h6, 4'h6, 1'b0, 4'hA};
        vecs[12] = '{1'b1, 1'b1, 4'h0, 4'd12, 4'h6, 4'h9, 1'b0, 4'hA};
        vecs[13] = '{1'b1, 1'b1, 4'h0, 4'd13, 4'h9, 4'h9, 1'b0, 4'hA};
        vecs[14] = '{1'b1, 1'b1, 4'h0, 4'd14, 4'h9, 4'h9, 1'b0, 4'h9};
        vecs[15] = '{1'b1, 1'b1, 4'h0, 4'd15, 4'h9, 4'h9, 1'b0, 4'h9};
        vecs[16] = '{1'b1, 1'b1, 4'h0, 4'd0,  4'h9, 4'h9, 1'b0, 4'h9};

        // ---- Reset held 3 cycles while cpu_en pulses: nothing executes
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'hF);
            chk_state($sformatf("reset%0d", i), 4'd0, 4'h0, 4'h0, 1'b0, 4'h0);
            chk("reset.halted", {3'b0, halted}, 4'd0);
        end

        // ---- Table-driven program run
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rn, vecs[i].en, vecs[i].inp);
            chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].a, vecs[i].b,
                      vecs[i].c, vecs[i].o);
        end

        // ---- Enable gating: MOV A,5 held off for 10 cycles, then one pulse
        clear_rom();
        rom[0] = 8'h35;
        step(1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'h0);
        chk_state("gate.idle", 4'd0, 4'h0, 4'h0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        chk_state("gate.pulse", 4'd1, 4'h5, 4'h0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        chk_state("gate.after", 4'd1, 4'h5, 4'h0, 1'b0, 4'h0);

        // ---- PC wrap and I/O: JMP 15, IN B at 15, wrap, OUT B at 0
        clear_rom();
        rom[0]  = 8'hFF;
        rom[15] = 8'h60;
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h9);
        chk("wrap.jmp_pc", rom_addr, 4'd15);
        rom[0] = 8'h90;
        step(1'b1, 1'b1, 4'h9);
        chk_state("wrap.inb", 4'd0, 4'h0, 4'h9, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h3);
        chk_state("wrap.outb", 4'd1, 4'h0, 4'h9, 1'b0, 4'h9);

        // ---- Mid-operation reset coincident with an ADD execute
        clear_rom();
        rom[0] = 8'h3E;
        rom[1] = 8'h03;
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        chk_state("midrst.mov", 4'd1, 4'hE, 4'h0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        chk_state("midrst.rst", 4'd0, 4'h0, 4'h0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        chk_state("midrst.resume", 4'd1, 4'hE, 4'h0, 1'b0, 4'h0);

        // ---- Halt detection: JMP 4 from 0 (not a self loop), then JMP 4 at 4
        clear_rom();
        rom[0] = 8'hF4;
        rom[4] = 8'hF4;
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        chk("halt.jmp_pc", rom_addr, 4'd4);
        chk("halt.not_self", {3'b0, halted}, 4'd0);
        step(1'b1, 1'b1, 4'h0);
        chk("halt.self_pc", rom_addr, 4'd4);
        chk("halt.set", {3'b0, halted}, {3'b0, HALT_EXP});
        step(1'b1, 1'b1, 4'h0);
        chk("halt.loop_pc", rom_addr, 4'd4);
        chk("halt.sticky", {3'b0, halted}, {3'b0, HALT_EXP});
        step(1'b0, 1'b0, 4'h0);
        chk("halt.cleared", {3'b0, halted}, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
